// File: rtl/carro_multi_ctrl.sv
// Falling-car controller: NUM_CARS independent cars with per-car
// IDLE/MOVING/WAIT state, exit pulses and a shared saturating exit count.
module carro_multi_ctrl #(
  parameter int NUM_CARS    = 4,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int SCREEN_H    = 480,
  parameter int STEP_W      = 4,
  parameter int RESPAWN_DLY = 8,
  parameter int CNT_W       = 8
) (
  input  logic                    iClk,
  input  logic                    iReset_n,
  input  logic [NUM_CARS-1:0]     iLoad,
  input  logic [NUM_CARS*X_W-1:0] iPosX,
  input  logic [NUM_CARS*Y_W-1:0] iPosY,
  input  logic                    iTick,
  input  logic [STEP_W-1:0]       iSpeed,
  input  logic [NUM_CARS-1:0]     iSalto,
  input  logic [X_W-1:0]          iAuxX,
  input  logic [Y_W-1:0]          iAuxY,
  output logic [NUM_CARS*X_W-1:0] oPosX,
  output logic [NUM_CARS*Y_W-1:0] oPosY,
  output logic [NUM_CARS-1:0]     oActive,
  output logic [NUM_CARS-1:0]     oExit,
  output logic [CNT_W-1:0]        oExitCount,
  output logic                    oAllIdle
);

  localparam int DLY_W = (RESPAWN_DLY > 0) ? $clog2(RESPAWN_DLY + 1) : 1;
  localparam int PC_W  = $clog2(NUM_CARS + 1);
  localparam int TOT_W = CNT_W + PC_W;
  localparam logic [Y_W-1:0] LP_YMAX = Y_W'(SCREEN_H - 1);
  localparam logic [Y_W-1:0] LP_YOFF = Y_W'(SCREEN_H);
  localparam logic [Y_W:0]   LP_HEXT = (Y_W+1)'(SCREEN_H);
  localparam logic [TOT_W-1:0] LP_SAT = TOT_W'({CNT_W{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_WAIT = 2'd2
  } st_t;

  st_t              r_st   [NUM_CARS];
  st_t              w_st   [NUM_CARS];
  logic [X_W-1:0]   r_x    [NUM_CARS];
  logic [X_W-1:0]   w_x    [NUM_CARS];
  logic [Y_W-1:0]   r_y    [NUM_CARS];
  logic [Y_W-1:0]   w_y    [NUM_CARS];
  logic [DLY_W-1:0] r_dly  [NUM_CARS];
  logic [DLY_W-1:0] w_dly  [NUM_CARS];
  logic [Y_W:0]     w_sum  [NUM_CARS];
  logic [Y_W-1:0]   w_ld_y [NUM_CARS];
  logic [Y_W-1:0]   w_aux_y;

  logic [NUM_CARS-1:0] r_active, w_active;
  logic [NUM_CARS-1:0] r_exit, w_exit;
  logic                r_idle, w_idle;
  logic [CNT_W-1:0]    r_count, w_count;
  logic [PC_W-1:0]     w_pop;
  logic [TOT_W-1:0]    w_tot;

  assign w_aux_y = (iAuxY >= LP_YOFF) ? LP_YMAX : iAuxY;

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
    logic [Y_W-1:0] w_py;
    assign w_py      = iPosY[g*Y_W +: Y_W];
    assign w_ld_y[g] = (w_py >= LP_YOFF) ? LP_YMAX : w_py;
    assign w_sum[g]  = {1'b0, r_y[g]} + (Y_W+1)'(iSpeed);
    assign oPosX[g*X_W +: X_W] = r_x[g];
    assign oPosY[g*Y_W +: Y_W] = r_y[g];
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int k = 0; k < NUM_CARS; k++) begin
        r_st[k]  <= S_IDLE;
        r_x[k]   <= '0;
        r_y[k]   <= '0;
        r_dly[k] <= '0;
      end
      r_active <= '0;
      r_exit   <= '0;
      r_idle   <= 1'b1;
      r_count  <= '0;
    end else begin
      for (int k = 0; k < NUM_CARS; k++) begin
        r_st[k]  <= w_st[k];
        r_x[k]   <= w_x[k];
        r_y[k]   <= w_y[k];
        r_dly[k] <= w_dly[k];
      end
      r_active <= w_active;
      r_exit   <= w_exit;
      r_idle   <= w_idle;
      r_count  <= w_count;
    end
  end

  // Per car: load beats jump beats tick.
  always_comb begin
    for (int k = 0; k < NUM_CARS; k++) begin
      w_st[k]   = r_st[k];
      w_x[k]    = r_x[k];
      w_y[k]    = r_y[k];
      w_dly[k]  = r_dly[k];
      w_exit[k] = 1'b0;
      priority case (1'b1)
        iLoad[k]: begin
          w_st[k] = S_MOVE;
          w_x[k]  = iPosX[k*X_W +: X_W];
          w_y[k]  = w_ld_y[k];
        end
        iSalto[k] && (r_st[k] != S_IDLE): begin
          w_st[k] = S_MOVE;
          w_x[k]  = iAuxX;
          w_y[k]  = w_aux_y;
        end
        iTick && (r_st[k] == S_MOVE): begin
          if (w_sum[k] < LP_HEXT) begin
            w_y[k] = w_sum[k][Y_W-1:0];
          end else begin
            w_y[k]    = LP_YOFF;
            w_exit[k] = 1'b1;
            w_dly[k]  = DLY_W'(RESPAWN_DLY);
            w_st[k]   = S_WAIT;
          end
        end
        iTick && (r_st[k] == S_WAIT): begin
          if (r_dly[k] == '0) begin
            w_st[k] = S_MOVE;
            w_x[k]  = iAuxX;
            w_y[k]  = '0;
          end else begin
            w_dly[k] = r_dly[k] - DLY_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_idle = 1'b1;
    w_pop  = '0;
    for (int k = 0; k < NUM_CARS; k++) begin
      w_active[k] = (w_st[k] == S_MOVE);
      w_idle      = w_idle & (w_st[k] == S_IDLE);
      w_pop       = w_pop + PC_W'(w_exit[k]);
    end
    w_tot   = TOT_W'(r_count) + TOT_W'(w_pop);
    w_count = (w_tot > LP_SAT) ? {CNT_W{1'b1}} : w_tot[CNT_W-1:0];
  end

  assign oActive    = r_active;
  assign oExit      = r_exit;
  assign oExitCount = r_count;
  assign oAllIdle   = r_idle;

endmodule

// File: tb/tb_carro_multi_ctrl.sv
// Scoreboard bench for carro_multi_ctrl: a behavioural car model predicts
// every cycle's outputs, a monitor compares them after each clock edge.
module tb_carro_multi_ctrl;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  iLoad = '0;
  logic [39:0] iPosX = '0;
  logic [35:0] iPosY = '0;
  logic        iTick = 1'b0;
  logic [3:0]  iSpeed = '0;
  logic [3:0]  iSalto = '0;
  logic [9:0]  iAuxX = '0;
  logic [8:0]  iAuxY = '0;
  logic [39:0] oPosX;
  logic [35:0] oPosY;
  logic [3:0]  oActive;
  logic [3:0]  oExit;
  logic [7:0]  oExitCount;
  logic        oAllIdle;

  carro_multi_ctrl dut (
    .iClk(clk), .iReset_n(rst_n),
    .iLoad(iLoad), .iPosX(iPosX), .iPosY(iPosY),
    .iTick(iTick), .iSpeed(iSpeed), .iSalto(iSalto),
    .iAuxX(iAuxX), .iAuxY(iAuxY),
    .oPosX(oPosX), .oPosY(oPosY), .oActive(oActive),
    .oExit(oExit), .oExitCount(oExitCount), .oAllIdle(oAllIdle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] px;
    logic [35:0] py;
    logic [3:0]  act;
    logic [3:0]  ex;
    logic [7:0]  cnt;
    logic        idle;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Model: mode 0 = idle, 1 = moving, 2 = waiting
  int m_mode[NC];
  int m_x[NC];
  int m_y[NC];
  int m_dly[NC];
  int m_exit[NC];
  int m_cnt;

  function automatic void model_reset();
    for (int k = 0; k < NC; k++) begin
      m_mode[k] = 0; m_x[k] = 0; m_y[k] = 0;
      m_dly[k] = 0; m_exit[k] = 0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_step(
    input logic [3:0] ld, input logic [39:0] px, input logic [35:0] py,
    input logic tk, input logic [3:0] sp, input logic [3:0] sl,
    input logic [9:0] ax, input logic [8:0] ay);
    int n;
    n = 0;
    for (int k = 0; k < NC; k++) begin
      m_exit[k] = 0;
      if (ld[k]) begin
        m_mode[k] = 1;
        m_x[k] = int'(px[k*10 +: 10]);
        m_y[k] = int'(py[k*9 +: 9]);
        if (m_y[k] > 479) m_y[k] = 479;
      end else if (sl[k] && m_mode[k] != 0) begin
        m_mode[k] = 1;
        m_x[k] = int'(ax);
        m_y[k] = (int'(ay) > 479) ? 479 : int'(ay);
      end else if (tk && m_mode[k] == 1) begin
        if (m_y[k] + int'(sp) < 480) m_y[k] = m_y[k] + int'(sp);
        else begin
          m_y[k] = 480; m_exit[k] = 1; m_dly[k] = 8; m_mode[k] = 2;
        end
      end else if (tk && m_mode[k] == 2) begin
        if (m_dly[k] == 0) begin
          m_mode[k] = 1; m_x[k] = int'(ax); m_y[k] = 0;
        end else m_dly[k]--;
      end
      n += m_exit[k];
    end
    m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
  endfunction

  function automatic exp_t mk();
    exp_t e;
    e = '0;
    e.idle = 1'b1;
    for (int k = 0; k < NC; k++) begin
      e.px[k*10 +: 10] = 10'(m_x[k]);
      e.py[k*9 +: 9]   = 9'(m_y[k]);
      e.act[k] = (m_mode[k] == 1);
      e.ex[k]  = (m_exit[k] != 0);
      if (m_mode[k] != 0) e.idle = 1'b0;
    end
    e.cnt = 8'(m_cnt);
    return e;
  endfunction

  task automatic drive(
    input logic [3:0] ld, input logic [39:0] px, input logic [35:0] py,
    input logic tk, input logic [3:0] sp, input logic [3:0] sl,
    input logic [9:0] ax, input logic [8:0] ay);
    @(posedge clk); #2;
    iLoad = ld; iPosX = px; iPosY = py; iTick = tk;
    iSpeed = sp; iSalto = sl; iAuxX = ax; iAuxY = ay;
    model_step(ld, px, py, tk, sp, sl, ax, ay);
    q.push_back(mk());
  endtask

  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {oPosX, oPosY, oActive, oExit, oExitCount, oAllIdle};
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle t=%0t: got px=%h py=%h act=%b ex=%b cnt=%0d idle=%b, expected px=%h py=%h act=%b ex=%b cnt=%0d idle=%b",
            $time, a.px, a.py, a.act, a.ex, a.cnt, a.idle,
            e.px, e.py, e.act, e.ex, e.cnt, e.idle);
        end
      end
    end
  end

  task automatic check_reset(input string name);
    n_chk++;
    if (oPosX !== '0 || oPosY !== '0 || oActive !== '0 || oExit !== '0
        || oExitCount !== '0 || oAllIdle !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got px=%h py=%h act=%b ex=%b cnt=%0d idle=%b, expected all zero with idle=1",
        name, oPosX, oPosY, oActive, oExit, oExitCount, oAllIdle);
    end
  endtask

  initial begin
    logic [39:0] px;
    logic [35:0] py;
    logic [3:0]  ld;
    model_reset();
    #12;
    check_reset("reset_state");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Slow fall to the bottom edge, exit, wait and respawn
    drive(4'b0001, 40'd100, 36'd0, 0, 4'd1, 0, 0, 0);
    repeat (479) drive(0, 0, 0, 1, 4'd1, 0, 0, 0);
    drive(0, 0, 0, 1, 4'd1, 0, 0, 0);
    drive(0, 0, 0, 0, 4'd1, 0, 10'd320, 0);
    repeat (9) drive(0, 0, 0, 1, 4'd0, 0, 10'd320, 0);
    drive(0, 0, 0, 1, 4'd0, 0, 10'd320, 0);

    // Simultaneous exits of cars 0 and 2
    px = '0; py = '0;
    px[0 +: 10] = 10'd11; px[20 +: 10] = 10'd22;
    py[0 +: 9] = 9'd475; py[18 +: 9] = 9'd475;
    drive(4'b0101, px, py, 0, 4'd5, 0, 0, 0);
    drive(0, 0, 0, 1, 4'd5, 0, 0, 0);
    drive(0, 0, 0, 0, 4'd5, 0, 0, 0);

    // Priority, jump clamp, jump on idle car
    drive(4'b0001, 40'd10, 36'd200, 0, 4'd0, 0, 0, 0);
    drive(4'b0001, 40'd50, 36'd60, 1, 4'd3, 4'b0001, 10'd7, 9'd9);
    drive(0, 0, 0, 0, 4'd0, 4'b0001, 10'd33, 9'd500);
    drive(0, 0, 0, 1, 4'd3, 4'b0010, 10'd44, 9'd100);
    drive(0, 0, 0, 0, 4'd0, 4'b0100, 10'd55, 9'd479);

    // Randomised traffic
    repeat (3000) begin
      ld = '0;
      for (int k = 0; k < NC; k++) ld[k] = ($urandom_range(15) == 0);
      px = {$urandom, $urandom};
      py = {$urandom, $urandom};
      drive(ld, px, py, 1'($urandom_range(1)), 4'($urandom),
            4'($urandom_range(31) == 0 ? $urandom : 0),
            10'($urandom), 9'($urandom));
    end

    // Asynchronous reset mid-flight
    drive(4'b1111, {10'd1, 10'd2, 10'd3, 10'd4}, {4{9'd470}}, 0, 4'd9, 0, 0, 0);
    drive(0, 0, 0, 1, 4'd9, 0, 0, 0);
    drive(0, 0, 0, 1, 4'd9, 0, 0, 0);
    @(posedge clk); #4;
    rst_n = 1'b0;
    q.delete();
    model_reset();
    #1;
    check_reset("async_reset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Saturating exit counter: 252, then 254, 255, still 255
    for (int r = 0; r < 66; r++) begin
      ld = (r < 63) ? 4'b1111 : 4'b0011;
      drive(ld, 40'd77, {4{9'd479}}, 0, 4'd0, 0, 0, 0);
      drive(0, 0, 0, 1, 4'd15, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 4'd0, 0, 0, 0);

    @(posedge clk); #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
